// File: rtl/lfp_pkg.sv
// Shared constants and types for the LFP dot-product datapath.
// Formats:
//   Q6.11 : 18-bit two's-complement fixed point, 11 fraction bits.
//   E3M4  : {sign, exp[2:0], mant[3:0]}, value = 1.mant * 2^(exp-4), exp==0 is zero.
//   E4M4  : {sign, exp[3:0], mant[3:0]}, value = 1.mant * 2^(exp-8), exp==0 is zero.
package lfp_pkg;

  localparam int Q_W    = 18;
  localparam int Q_FRAC = 11;
  localparam int E3M4_W = 8;
  localparam int E4M4_W = 9;

  localparam logic [E3M4_W-1:0] E3M4_ONE  = 8'h40;
  localparam int                E3M4_BIAS = int'(E3M4_ONE[6:4]);

  localparam logic [Q_W-1:0] Q6_11_MAX = 18'h1FFFF;
  localparam logic [Q_W-1:0] Q6_11_MIN = 18'h20000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dot_state_t;

endpackage

// File: rtl/lfp_mac_pipe.sv
// Two-stage LFP multiply lane: Q6.11 x E3M4 -> Q6.11 product.
// Stage 1 converts the activation to E3M4 and multiplies into E4M4.
// Stage 2 converts the E4M4 product back to Q6.11 (magnitude clamped to 18'h1FFFF).
module lfp_mac_pipe
  import lfp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [Q_W-1:0]    x_q,
  input  logic [E3M4_W-1:0] w_fp,
  output logic              prod_valid,
  output logic [Q_W-1:0]    prod_q
);

  // Truncating conversion; magnitudes below 2^-3 flush to zero, above 15.5 saturate.
  function automatic logic [E3M4_W-1:0] q6_11_to_e3m4(input logic [Q_W-1:0] x);
    logic           sgn;
    logic [Q_W-1:0] mag;
    int             p;
    logic [E3M4_W-1:0] r;
    sgn = x[Q_W-1];
    mag = sgn ? (~x + 18'd1) : x;
    p = -1;
    for (int i = 0; i < Q_W; i++) begin
      if (mag[i]) p = i;
    end
    r = '0;
    if (p > Q_FRAC + 3) begin
      r = {sgn, 3'd7, 4'hF};
    end else if (p >= Q_FRAC - 3) begin
      r = {sgn, 3'(p - Q_FRAC + E3M4_BIAS), 4'(mag >> (p - 4))};
    end
    return r;
  endfunction

  // E3M4 x E3M4 -> E4M4; biases 4+4 map onto the E4M4 bias of 8, mantissa truncated.
  function automatic logic [E4M4_W-1:0] lfp_mult_e3m4(input logic [E3M4_W-1:0] a,
                                                      input logic [E3M4_W-1:0] b);
    logic [4:0] e;
    logic [9:0] prod;
    logic [3:0] m;
    if (a[6:4] == 3'd0 || b[6:4] == 3'd0) return '0;
    e    = {2'b00, a[6:4]} + {2'b00, b[6:4]};
    prod = 10'({1'b1, a[3:0]}) * 10'({1'b1, b[3:0]});
    if (prod[9]) begin
      e = e + 5'd1;
      m = 4'(prod >> 5);
    end else begin
      m = 4'(prod >> 4);
    end
    return {a[7] ^ b[7], e[3:0], m};
  endfunction

  function automatic logic [Q_W-1:0] e4m4_to_q6_11(input logic [E4M4_W-1:0] p);
    logic [19:0]    mag;
    logic [Q_W-1:0] r;
    if (p[7:4] == 4'd0) return '0;
    mag = 20'({1'b1, p[3:0]}) << (p[7:4] - 4'd1);
    if (mag > 20'h1FFFF) mag = 20'h1FFFF;
    r = 18'(mag);
    return p[8] ? (~r + 18'd1) : r;
  endfunction

  logic              s1_valid;
  logic [E4M4_W-1:0] s1_prod;

  // Stage 1: convert and multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_prod  <= lfp_mult_e3m4(q6_11_to_e3m4(x_q), w_fp);
    end
  end

  // Stage 2: back to fixed point for the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_valid <= 1'b0;
      prod_q     <= '0;
    end else begin
      prod_valid <= s1_valid;
      prod_q     <= e4m4_to_q6_11(s1_prod);
    end
  end

endmodule

// File: rtl/lfp_dot_sched.sv
// Sequential dot-product scheduler: streams (Q6.11, E3M4) pairs through one
// pipelined multiply lane and returns the Q6.11 sum over valid/ready.
// Build option: LFP_DOT_SAT_EN saturates out_q on overflow; otherwise out_q wraps.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for start; acc/cnt cleared on launch
// ST_RUN   | accepting pairs while cnt < len_r
// ST_DRAIN | all pairs accepted, waiting for lane to empty
// ST_DONE  | result presented until out_ready
module lfp_dot_sched
  import lfp_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7,
  parameter int ACC_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Q_W-1:0]    x_q,
  input  logic [E3M4_W-1:0] w_fp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_W-1:0]    out_q,
  output logic              out_ovf
);

  dot_state_t       state, state_nxt;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_clamped;
  logic [1:0]       inflight;
  logic [1:0]       inflight_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [Q_W-1:0]   out_q_r;
  logic             out_ovf_r;
  logic             fire;
  logic             prod_valid;
  logic [Q_W-1:0]   prod_q;
  logic             acc_ovf;
  logic [Q_W-1:0]   acc_res;
  logic [ACC_W-Q_W:0] acc_hi;

  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_RUN) && (cnt < len_r);
  assign fire      = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign out_q     = out_q_r;
  assign out_ovf   = out_ovf_r;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  lfp_mac_pipe u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (fire),
    .x_q        (x_q),
    .w_fp       (w_fp),
    .prod_valid (prod_valid),
    .prod_q     (prod_q)
  );

  // Accumulator input, in-flight tracking and result formatting.
  always_comb begin
    acc_nxt      = acc;
    inflight_nxt = inflight + 2'(fire) - 2'(prod_valid);
    if (prod_valid) acc_nxt = acc + {{(ACC_W-Q_W){prod_q[Q_W-1]}}, prod_q};
    acc_hi  = acc_nxt[ACC_W-1:Q_W-1];
    acc_ovf = !((&acc_hi) || !(|acc_hi));
`ifdef LFP_DOT_SAT_EN
    acc_res = acc_ovf ? (acc_nxt[ACC_W-1] ? Q6_11_MIN : Q6_11_MAX) : acc_nxt[Q_W-1:0];
`else
    acc_res = acc_nxt[Q_W-1:0];
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (fire && (cnt + LEN_W'(1) == len_r)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight_nxt == 2'd0) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Length capture, element counter, in-flight counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r    <= '0;
      cnt      <= '0;
      inflight <= '0;
      acc      <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (state == ST_IDLE) begin
        if (start) len_r <= len_clamped;
        cnt <= '0;
        acc <= '0;
      end else begin
        if (fire) cnt <= cnt + LEN_W'(1);
        acc <= acc_nxt;
      end
    end
  end

  // Result register: loaded on entry to DONE, cleared after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_r   <= '0;
      out_ovf_r <= 1'b0;
    end else if (state == ST_DONE) begin
      if (out_ready) begin
        out_q_r   <= '0;
        out_ovf_r <= 1'b0;
      end
    end else if (state_nxt == ST_DONE) begin
      if (state == ST_IDLE) begin
        out_q_r   <= '0;
        out_ovf_r <= 1'b0;
      end else begin
        out_q_r   <= acc_res;
        out_ovf_r <= acc_ovf;
      end
    end
  end

endmodule

// File: tb/tb_lfp_dot_sched.sv
// Scoreboard bench for lfp_dot_sched: stimulus pushes expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_lfp_dot_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  len = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] x_q = '0;
  logic [7:0]  w_fp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] out_q;
  logic        out_ovf;

  lfp_dot_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_q       (x_q),
    .w_fp      (w_fp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] q;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_exp = 0;
  int   acc_cnt = 0;
  int   rise_cyc = -1;
  int   sc;
  logic prev_ov = 1'b0;

  localparam logic [7:0] W_ONE = 8'h40;

`ifdef LFP_DOT_SAT_EN
  localparam logic [17:0] OVF_Q = 18'h1FFFF;
`else
  localparam logic [17:0] OVF_Q = 18'h28000;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts accepted pairs, records out_valid rise, scores results.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", out_q);
        end else begin
          e_pop = sb.pop_front();
          check("out_q", 32'(out_q), 32'(e_pop.q));
          check("out_ovf", 32'(out_ovf), 32'(e_pop.ovf));
        end
        n_out++;
      end
    end
    prev_ov = out_valid;
  end

  task automatic expect_result(input logic [17:0] q, input logic ovf);
    sb.push_back('{q: q, ovf: ovf});
    n_exp++;
  endtask

  task automatic do_start(input int n, output int s);
    @(posedge clk); #1;
    start = 1'b1;
    len = 7'(n);
    acc_cnt = 0;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [17:0] xv, input logic [7:0] wv, input int gap);
    logic ok;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    x_q = xv;
    w_fp = wv;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_out(input int target);
    for (int t = 0; t < 300; t++) begin
      if (n_out >= target) break;
      @(posedge clk); #1;
    end
    if (n_out < target) check("result_timeout", 32'(n_out), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_q", 32'(out_q), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // len=4 of 1.0 x 1.0, in_valid held high.
    expect_result(18'h02000, 1'b0);
    do_start(4, sc);
    for (int i = 0; i < 4; i++) send(18'h00800, W_ONE, 0);
    wait_out(n_exp);
    check("t1_latency", 32'(rise_cyc - sc), 32'd7);
    check("t1_accepted", 32'(acc_cnt), 32'd4);

    // len=3 with toggling in_valid and back-pressured output.
    out_ready = 1'b0;
    expect_result(18'h01800, 1'b0);
    do_start(3, sc);
    send(18'h00800, W_ONE, 0);
    send(18'h00800, W_ONE, 1);
    send(18'h00800, W_ONE, 1);
    for (int t = 0; t < 50; t++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_q", 32'(out_q), 32'h01800);
      check("t2_no_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    len = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t2_start_at_ack_busy", 32'(busy), 32'd0);
    check("t2_start_at_ack_valid", 32'(out_valid), 32'd0);
    check("t2_accepted", 32'(acc_cnt), 32'd3);
    wait_out(n_exp);

    // len=20 of 4.0 overflows the Q6.11 range.
    expect_result(OVF_Q, 1'b1);
    do_start(20, sc);
    for (int i = 0; i < 20; i++) send(18'h02000, W_ONE, 0);
    wait_out(n_exp);

    // Mixed signs cancel.
    expect_result(18'h00000, 1'b0);
    do_start(2, sc);
    send(18'h01000, W_ONE, 0);
    send(18'h3F000, W_ONE, 0);
    wait_out(n_exp);

    // len=0 returns zero the cycle after start.
    expect_result(18'h00000, 1'b0);
    do_start(0, sc);
    wait_out(n_exp);
    check("t5_len0_latency", 32'(rise_cyc - sc), 32'd1);

    // start during RUN is ignored.
    expect_result(18'h01800, 1'b0);
    do_start(3, sc);
    send(18'h00800, W_ONE, 0);
    start = 1'b1;
    len = 7'd1;
    @(posedge clk); #1;
    start = 1'b0;
    send(18'h00800, W_ONE, 0);
    send(18'h00800, W_ONE, 0);
    wait_out(n_exp);
    check("t5_accepted", 32'(acc_cnt), 32'd3);

    // Reset mid-RUN, then a clean len=1 vector.
    do_start(8, sc);
    send(18'h00800, W_ONE, 0);
    send(18'h00800, W_ONE, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_result(18'h00800, 1'b0);
    do_start(1, sc);
    send(18'h00800, W_ONE, 0);
    wait_out(n_exp);

    repeat (3) @(posedge clk);
    check("outputs_seen", 32'(n_out), 32'd7);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
